rx_frame_writer: RTL

- Sits directly downstream of the CC1200 SPI receive path.
- Consumes the 12-bit pixel stream (RxData/RxValid) and the FrameSync/LineSync header-match flags.
- Turns them into linear frame-buffer write transactions on a simple BRAM write port, with line/frame counters, resynchronisation, and sticky framing-error flags for the APB register block.

---
 rtl/rx_frame_pkg.sv | 21 ++
 rtl/rx_frame_writer_if.sv | 23 ++
 rtl/rx_sync_edge.sv | 24 ++
 rtl/rx_frame_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared constants for the CC1200 receive path: frame-writer state codes,
// header sync words and default frame geometry.
package rx_frame_pkg;

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_WAIT_FRAME = 2'b01;
    localparam logic [1:0] ST_IN_LINE    = 2'b10;
    localparam logic [1:0] ST_WAIT_LINE  = 2'b11;

    localparam logic [31:0] FRAME_SYNC_WORD = 32'h930b51de;
    localparam logic [31:0] LINE_SYNC_WORD  = 32'h6cf4ae21;

    localparam int DEF_H_PIXELS = 320;
    localparam int DEF_V_LINES  = 240;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_frame_writer_if.sv
// Pixel stream from the SPI receiver plus the frame-buffer write port.
interface rx_frame_writer_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17
);
    logic [PIX_W-1:0]  RxData;
    logic              RxValid;
    logic              FrameSync;
    logic              LineSync;
    logic [ADDR_W-1:0] MemAddr;
    logic [PIX_W-1:0]  MemData;
    logic              MemWe;

    modport master (
        output RxData, RxValid, FrameSync, LineSync,
        input  MemAddr, MemData, MemWe
    );

    modport slave (
        input  RxData, RxValid, FrameSync, LineSync,
        output MemAddr, MemData, MemWe
    );
endinterface

// File: rtl/rx_sync_edge.sv
// Registers a header-match level once more and emits a one-cycle pulse on
// its rising edge, so a header held for several cycles counts once.
module rx_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic level,
    output logic pulse
);
    logic cur;
    logic prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so prev takes the pre-edge value of cur.
            cur  <= level;
            prev <= cur;
        end
    end

    assign pulse = cur & ~prev;
endmodule

// File: rtl/rx_frame_writer.sv
// Converts the received pixel stream and sync headers into linear frame-buffer
// writes, tracking line/frame position and sticky framing errors.
module rx_frame_writer
    import rx_frame_pkg::*;
#(
    parameter int PIX_W    = 12,
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int ADDR_W   = 17
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    Enable,
    rx_frame_writer_if.slave        bus,
    input  logic                    ErrClr,
    output logic                    FrameDone,
    output logic [15:0]             FrameCount,
    output logic [15:0]             LineCount,
    output logic                    ErrShort,
    output logic                    ErrLong,
    output logic                    Busy
);
    localparam int PIX_CW  = cnt_width(H_PIXELS);
    localparam int LINE_CW = cnt_width(V_LINES);
    localparam logic [PIX_CW-1:0]  PIX_LAST  = PIX_CW'(H_PIXELS - 1);
    localparam logic [LINE_CW-1:0] LINE_LAST = LINE_CW'(V_LINES - 1);

    logic [1:0]         state, state_n;
    logic [PIX_CW-1:0]  pix, pix_n;
    logic [LINE_CW-1:0] line, line_n;
    logic [ADDR_W-1:0]  line_base, base_n;
    logic               we_n, done_n, set_short, set_long;
    logic               fs_p, ls_p;

    rx_sync_edge u_fs_edge (.clk(clk), .rstn(rstn), .level(bus.FrameSync), .pulse(fs_p));
    rx_sync_edge u_ls_edge (.clk(clk), .rstn(rstn), .level(bus.LineSync),  .pulse(ls_p));

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n   = state;
        pix_n     = pix;
        line_n    = line;
        base_n    = line_base;
        we_n      = 1'b0;
        done_n    = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;

        if (!Enable) begin
            state_n = ST_IDLE;
            pix_n   = '0;
            line_n  = '0;
            base_n  = '0;
        end else begin
            case (state)
                ST_IDLE: state_n = ST_WAIT_FRAME;
                ST_WAIT_FRAME: begin
                    if (fs_p) begin
                        state_n = ST_IN_LINE;
                        pix_n   = '0;
                        line_n  = '0;
                        base_n  = '0;
                    end
                end
                ST_IN_LINE, ST_WAIT_LINE: begin
                    if (fs_p) begin
                        set_short = (line != '0) || (pix != '0);
                        state_n   = ST_IN_LINE;
                        pix_n     = '0;
                        line_n    = '0;
                        base_n    = '0;
                    end else if (ls_p) begin
                        if (state == ST_WAIT_LINE) begin
                            state_n = ST_IN_LINE;
                            pix_n   = '0;
                        end else if (pix != '0) begin
                            // Early header: the new line opens immediately.
                            set_short = 1'b1;
                            if (line == LINE_LAST) begin
                                state_n = ST_WAIT_FRAME;
                            end else begin
                                line_n = line + 1'b1;
                                base_n = line_base + ADDR_W'(H_PIXELS);
                                pix_n  = '0;
                            end
                        end
                    end else if (bus.RxValid) begin
                        if (state == ST_WAIT_LINE) begin
                            set_long = 1'b1;
                        end else begin
                            we_n = 1'b1;
                            if (pix != PIX_LAST) begin
                                pix_n = pix + 1'b1;
                            end else if (line == LINE_LAST) begin
                                done_n  = 1'b1;
                                state_n = ST_WAIT_FRAME;
                            end else begin
                                line_n  = line + 1'b1;
                                base_n  = line_base + ADDR_W'(H_PIXELS);
                                pix_n   = '0;
                                state_n = ST_WAIT_LINE;
                            end
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            pix         <= '0;
            line        <= '0;
            line_base   <= '0;
            bus.MemAddr <= '0;
            bus.MemData <= '0;
            bus.MemWe   <= 1'b0;
            FrameDone   <= 1'b0;
            FrameCount  <= '0;
            ErrShort    <= 1'b0;
            ErrLong     <= 1'b0;
        end else begin
            state     <= state_n;
            pix       <= pix_n;
            line      <= line_n;
            line_base <= base_n;
            bus.MemWe <= we_n;
            FrameDone <= done_n;
            if (we_n) begin
                bus.MemAddr <= line_base + ADDR_W'(pix);
                bus.MemData <= bus.RxData;
            end
            if (done_n) FrameCount <= FrameCount + 16'd1;
            // A new error in the clearing cycle keeps its flag set.
            ErrShort <= set_short | (ErrShort & ~ErrClr);
            ErrLong  <= set_long  | (ErrLong  & ~ErrClr);
        end
    end

    assign LineCount = 16'(line);
    assign Busy      = (state == ST_IN_LINE) || (state == ST_WAIT_LINE);
endmodule
